// File: rtl/ppu_pool_pkg.sv
// Shared types and elaboration helpers for the PPU pooling reducer.
//   pool_mode_e : reduction mode (max / floor-average)
//   acc_w()     : accumulator width for a window of WIN elements of DATA_W bits
//   win_ok()    : true when WIN is a power of two in 2..16
package ppu_pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // A sum of WIN elements needs log2(WIN) extra bits of headroom.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned win);
        return data_w + $clog2(win);
    endfunction

    function automatic bit win_ok(input int unsigned win);
        return (win >= 2) && (win <= 16) && ((win & (win - 1)) == 0);
    endfunction

endpackage

// File: rtl/ppu_pool_lane.sv
// Single-lane pooling accumulator.
//   clk, rst     : clock, async active-high reset
//   i_accept     : a beat is consumed this cycle
//   i_first      : this beat is element 0 of a window (load instead of combine)
//   i_mode       : effective mode for this beat
//   i_elem       : lane element
//   o_result_c   : combinational window result, valid on the final beat
module ppu_pool_lane
    import ppu_pool_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIN    = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic              i_first,
    input  pool_mode_e        i_mode,
    input  logic [DATA_W-1:0] i_elem,
    output logic [DATA_W-1:0] o_result_c
);

    localparam int unsigned ACC_W = acc_w(DATA_W, WIN);
    localparam int unsigned SH    = $clog2(WIN);

    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        w_ext;
    logic [ACC_W-1:0]        w_max;
    logic [ACC_W-1:0]        w_next;
    logic [ACC_W-1:0]        w_avg;
    logic signed [ACC_W-1:0] w_ext_s;
    logic signed [ACC_W-1:0] w_acc_s;
    logic signed [ACC_W-1:0] w_next_s;
    logic                    w_gt;

    // Extend, combine with the running value, and form the window result.
    always_comb begin
        w_ext    = {{SH{SIGNED & i_elem[DATA_W-1]}}, i_elem};
        w_ext_s  = w_ext;
        w_acc_s  = r_acc;
        w_gt     = SIGNED ? (w_ext_s > w_acc_s) : (w_ext > r_acc);
        w_max    = w_gt ? w_ext : r_acc;
        if (i_first) begin
            w_next = w_ext;
        end else if (i_mode == POOL_AVG) begin
            w_next = r_acc + w_ext;
        end else begin
            w_next = w_max;
        end
        w_next_s = w_next;
        // Shift kept in separate branches so the signed case stays arithmetic.
        if (SIGNED) begin
            w_avg = w_next_s >>> SH;
        end else begin
            w_avg = w_next >> SH;
        end
        o_result_c = (i_mode == POOL_AVG) ? w_avg[DATA_W-1:0] : w_next[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_accept) begin
            r_acc <= w_next;
        end
    end

endmodule

// File: rtl/ppu_pool_reducer.sv
// Multi-lane pooling reducer: one reduced beat out per WIN accepted beats.
//   clk, rst       : clock, async active-high reset
//   i_init_window  : restart the window (pending output untouched)
//   i_mode         : 0 = max, 1 = average; latched on element 0
//   i_in_valid / o_in_ready / i_in_data   : input beat handshake, CH lanes
//   o_out_valid / i_out_ready / o_out_data : registered result handshake
module ppu_pool_reducer
    import ppu_pool_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned WIN    = 4,
    parameter int unsigned CH     = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_init_window,
    input  logic                 i_mode,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [CH*DATA_W-1:0] i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [CH*DATA_W-1:0] o_out_data
);

    localparam int unsigned      CNT_W    = $clog2(WIN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

    if (!win_ok(WIN)) begin : g_bad_win
        $error("ppu_pool_reducer: WIN must be a power of two in 2..16");
    end

    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_base;
    logic [CNT_W-1:0]    w_cnt_next;
    pool_mode_e          r_mode;
    pool_mode_e          w_mode;
    logic                w_accept;
    logic                w_first;
    logic                w_last;
    logic                r_out_valid;
    logic [CH*DATA_W-1:0] r_out_data;
    logic [CH*DATA_W-1:0] w_result;

    // Only a final beat can stall, and only behind an undrained result.
    assign o_in_ready = !((r_cnt == CNT_LAST) && r_out_valid && !i_out_ready);
    assign w_accept   = i_in_valid && o_in_ready;

    // init_window makes this cycle's beat element 0 of a fresh window.
    assign w_cnt_base = i_init_window ? '0 : r_cnt;
    assign w_first    = (w_cnt_base == '0);
    assign w_last     = (w_cnt_base == CNT_LAST);
    assign w_cnt_next = w_cnt_base + CNT_W'(1);   // WIN is a power of two, so this wraps
    assign w_mode     = w_first ? pool_mode_e'(i_mode) : r_mode;

    for (genvar g = 0; g < CH; g++) begin : g_lane
        ppu_pool_lane #(
            .DATA_W (DATA_W),
            .WIN    (WIN),
            .SIGNED (SIGNED)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_accept   (w_accept),
            .i_first    (w_first),
            .i_mode     (w_mode),
            .i_elem     (i_in_data[g*DATA_W +: DATA_W]),
            .o_result_c (w_result[g*DATA_W +: DATA_W])
        );
    end

    // Window counter, mode latch and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mode      <= POOL_MAX;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_cnt <= w_accept ? w_cnt_next : w_cnt_base;
            if (w_accept && w_first) begin
                r_mode <= pool_mode_e'(i_mode);
            end
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_ppu_pool_reducer.sv
// Bench for ppu_pool_reducer: an unsigned and a signed instance share one
// stimulus stream; a window-level model predicts both every cycle.
module tb_ppu_pool_reducer;

    localparam int unsigned DW  = 8;
    localparam int unsigned WIN = 4;
    localparam int unsigned CH  = 4;

    logic           clk;
    logic           rst;
    logic           init_window;
    logic           mode;
    logic           in_valid;
    logic [CH*DW-1:0] in_data;
    logic           out_ready;
    logic           ready_u, ready_s;
    logic           ov_u, ov_s;
    logic [CH*DW-1:0] od_u, od_s;

    int n_checks = 0;
    int n_fail   = 0;

    ppu_pool_reducer #(.DATA_W(DW), .WIN(WIN), .CH(CH), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .i_init_window(init_window), .i_mode(mode),
        .i_in_valid(in_valid), .o_in_ready(ready_u), .i_in_data(in_data),
        .o_out_valid(ov_u), .i_out_ready(out_ready), .o_out_data(od_u)
    );

    ppu_pool_reducer #(.DATA_W(DW), .WIN(WIN), .CH(CH), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .i_init_window(init_window), .i_mode(mode),
        .i_in_valid(in_valid), .o_in_ready(ready_s), .i_in_data(in_data),
        .o_out_valid(ov_s), .i_out_ready(out_ready), .o_out_data(od_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] lane(input logic [31:0] v, input int l);
        return v[l*8 +: 8];
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // ---------------- behavioural model ----------------
    int          m_n;               // beats collected in the current window
    bit          m_mode;            // mode of the current window
    bit          m_ov;              // a result is pending
    logic [31:0] m_du, m_ds;        // expected outputs (unsigned / signed instance)
    int          bu[WIN][CH];
    int          bs[WIN][CH];
    bit          m_acc, m_fin;
    logic [7:0]  m_e;
    logic signed [7:0] m_es;

    function automatic bit exp_ready();
        return !(m_n == WIN - 1 && m_ov && !out_ready);
    endfunction

    task automatic finish_window();
        for (int l = 0; l < CH; l++) begin
            int ru, rs, su, ss;
            if (m_mode == 1'b0) begin
                ru = bu[0][l];
                rs = bs[0][l];
                for (int k = 1; k < WIN; k++) begin
                    if (bu[k][l] > ru) ru = bu[k][l];
                    if (bs[k][l] > rs) rs = bs[k][l];
                end
            end else begin
                su = 0;
                ss = 0;
                for (int k = 0; k < WIN; k++) begin
                    su += bu[k][l];
                    ss += bs[k][l];
                end
                ru = floor_div(su, WIN);
                rs = floor_div(ss, WIN);
            end
            m_du[l*8 +: 8] = 8'(ru);
            m_ds[l*8 +: 8] = 8'(rs);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n    = 0;
            m_mode = 1'b0;
            m_ov   = 1'b0;
            m_du   = '0;
            m_ds   = '0;
        end else begin
            m_acc = in_valid && exp_ready();
            m_fin = 1'b0;
            if (init_window) m_n = 0;
            if (m_acc) begin
                if (m_n == 0) m_mode = mode;
                for (int l = 0; l < CH; l++) begin
                    m_e  = in_data[l*8 +: 8];
                    m_es = m_e;
                    bu[m_n][l] = int'(m_e);
                    bs[m_n][l] = int'(m_es);
                end
                m_n++;
                if (m_n == WIN) begin
                    finish_window();
                    m_fin = 1'b1;
                    m_n   = 0;
                end
            end
            if (m_fin) m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_u",  32'(ready_u), 32'(exp_ready()));
            check("in_ready_s",  32'(ready_s), 32'(exp_ready()));
            check("out_valid_u", 32'(ov_u), 32'(m_ov));
            check("out_valid_s", 32'(ov_s), 32'(m_ov));
            check("out_data_u",  od_u, m_du);
            check("out_data_s",  od_s, m_ds);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [31:0] d, input logic m, input logic init);
        bit ok;
        in_valid    = 1'b1;
        in_data     = d;
        mode        = m;
        init_window = init;
        #1;
        ok = 1'b0;
        repeat (50) begin
            if (ready_u) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
        step();
        in_valid    = 1'b0;
        init_window = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        init_window = 1'b0;
        mode        = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        repeat (3) step();
        check("reset_out_valid", 32'(ov_u), 32'd0);
        check("reset_out_data",  od_u, 32'd0);
        check("reset_in_ready",  32'(ready_u), 32'd1);
        rst = 1'b0;
        step();

        // Unsigned max
        send_beat(pack4(8'd3,   8'd1, 8'd2, 8'd255), 1'b0, 1'b0);
        send_beat(pack4(8'd200, 8'd1, 8'd2, 8'd0),   1'b0, 1'b0);
        send_beat(pack4(8'd17,  8'd1, 8'd2, 8'd0),   1'b0, 1'b0);
        send_beat(pack4(8'd9,   8'd1, 8'd2, 8'd1),   1'b0, 1'b0);
        check("max_valid", 32'(ov_u), 32'd1);
        check("max_lane0", 32'(lane(od_u, 0)), 32'd200);
        check("max_lane3", 32'(lane(od_u, 3)), 32'd255);

        // Average: -1,-2,-2,-2 -> -2 signed; 127,127,127,126 -> 126
        send_beat({4{8'hFF}}, 1'b1, 1'b0);
        send_beat({4{8'hFE}}, 1'b1, 1'b0);
        send_beat({4{8'hFE}}, 1'b1, 1'b0);
        send_beat({4{8'hFE}}, 1'b1, 1'b0);
        check("avg_neg_s", 32'(lane(od_s, 2)), 32'hFE);
        send_beat({4{8'd127}}, 1'b1, 1'b0);
        send_beat({4{8'd127}}, 1'b1, 1'b0);
        send_beat({4{8'd127}}, 1'b1, 1'b0);
        send_beat({4{8'd126}}, 1'b1, 1'b0);
        check("avg_pos_s", 32'(lane(od_s, 1)), 32'd126);

        // Backpressure
        step();
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) send_beat({4{8'(k)}}, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = {4{8'd8}};
        mode     = 1'b0;
        #1;
        check("bp_stall_ready", 32'(ready_u), 32'd0);
        step();
        step();
        check("bp_hold_valid", 32'(ov_u), 32'd1);
        check("bp_hold_data", 32'(lane(od_u, 0)), 32'd4);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(ready_u), 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("bp_second_valid", 32'(ov_u), 32'd1);
        check("bp_second_data", 32'(lane(od_u, 0)), 32'd8);

        // init_window with a pending result
        send_beat({4{8'd50}}, 1'b0, 1'b0);
        send_beat({4{8'd60}}, 1'b0, 1'b0);
        send_beat({4{8'd10}}, 1'b0, 1'b1);
        send_beat({4{8'd1}},  1'b0, 1'b0);
        send_beat({4{8'd1}},  1'b0, 1'b0);
        check("init_pending_data", 32'(lane(od_u, 0)), 32'd8);
        out_ready = 1'b1;
        send_beat({4{8'd1}}, 1'b0, 1'b0);
        check("init_result", 32'(lane(od_u, 0)), 32'd10);

        // Mode latched on element 0 only
        send_beat({4{8'd4}},  1'b1, 1'b0);
        send_beat({4{8'd8}},  1'b0, 1'b0);
        send_beat({4{8'd8}},  1'b0, 1'b0);
        send_beat({4{8'd12}}, 1'b0, 1'b0);
        check("mode_latch", 32'(lane(od_u, 0)), 32'd8);

        // Reset mid-window with a pending result
        out_ready = 1'b0;
        send_beat({4{8'd100}}, 1'b0, 1'b0);
        send_beat({4{8'd100}}, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(ov_u), 32'd0);
        check("rst_mid_data",  od_s, 32'd0);
        check("rst_mid_ready", 32'(ready_u), 32'd1);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        send_beat({4{8'd7}}, 1'b0, 1'b0);
        send_beat({4{8'd7}}, 1'b0, 1'b0);
        send_beat({4{8'd7}}, 1'b0, 1'b0);
        send_beat({4{8'd9}}, 1'b0, 1'b0);
        check("rst_fresh_window", 32'(lane(od_u, 0)), 32'd9);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = $urandom;
            if (c % 300 < 100) in_data = in_data & {4{8'h83}};
            mode        = 1'($urandom_range(0, 1));
            init_window = ($urandom_range(0, 24) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid    = 1'b0;
        init_window = 1'b0;
        out_ready   = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
